// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//
// Arbitrates the register file's single write port between the in-order
// writeback stage (primary, always wins) and long-latency producers such as
// the MDU (secondary). Secondary results wait in a small FIFO and drain on
// cycles the primary leaves the port idle. A busy scoreboard tracks
// registers with outstanding long-latency results so decode can stall.
//
// Optional feature: define RF_ARB_STARVE_EN to enable the starvation guard,
// which raises stall_req after STARVE_LIMIT consecutive cycles in which the
// FIFO head was denied the port. With it undefined, stall_req is tied low.
//
// Parameters
//   DEPTH         secondary FIFO entries (power of two, 2..8)
//   STARVE_LIMIT  denied cycles before stall_req asserts (1..15)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   wb_valid/addr/data/pc     primary write request (addr 0 = idle)
//   lu_valid/addr/data/pc     secondary write request, lu_ready = accept
//   issue_valid, issue_addr   long op issued; marks destination busy
//   query_addr1/2, busy1/2    decode scoreboard lookups
//   rf_write_enable/addr/data, rf_curr_pc   register file write port
//   stall_req                 asks the pipeline for a writeback bubble

module rf_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,

    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    input  logic [31:0] lu_pc,

    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,

    input  logic [4:0]  query_addr1,
    input  logic [4:0]  query_addr2,
    output logic        busy1,
    output logic        busy2,

    output logic        rf_write_enable,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_write_data,
    output logic [31:0] rf_curr_pc,

    output logic        stall_req
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rf_write_arbiter: DEPTH must be a power of two in 2..8");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("rf_write_arbiter: STARVE_LIMIT must be in 1..15");
    end

    // ------------------------------------------------------------------
    // Secondary FIFO
    // ------------------------------------------------------------------
    logic [4:0]  fifo_addr [DEPTH];
    logic [31:0] fifo_data [DEPTH];
    logic [31:0] fifo_pc   [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic fifo_empty;
    logic fifo_full;
    logic head_valid;
    logic primary_active;
    logic push;
    logic pop;

    assign fifo_empty     = (count == '0);
    assign fifo_full      = (count == (AW+1)'(DEPTH));
    // Queued entries are invisible during reset; they are discarded at the edge.
    assign head_valid     = !fifo_empty && !rst;
    assign primary_active = wb_valid && (wb_addr != 5'd0);

    // No pass-through when full: a pop in the same cycle does not free a slot.
    assign lu_ready = !fifo_full && !rst;
    // Writes to r0 are accepted for handshake purposes but never stored.
    assign push     = lu_valid && lu_ready && (lu_addr != 5'd0);
    assign pop      = head_valid && !primary_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lu_addr;
            fifo_data[wr_ptr] <= lu_data;
            fifo_pc[wr_ptr]   <= lu_pc;
        end
    end

    // ------------------------------------------------------------------
    // Write port select
    // ------------------------------------------------------------------
    always_comb begin
        rf_write_enable = 1'b0;
        rf_write_addr   = 5'd0;
        rf_write_data   = 32'd0;
        rf_curr_pc      = 32'd0;
        if (primary_active) begin
            rf_write_enable = 1'b1;
            rf_write_addr   = wb_addr;
            rf_write_data   = wb_data;
            rf_curr_pc      = wb_pc;
        end else if (head_valid) begin
            rf_write_enable = 1'b1;
            rf_write_addr   = fifo_addr[rd_ptr];
            rf_write_data   = fifo_data[rd_ptr];
            rf_curr_pc      = fifo_pc[rd_ptr];
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard
    // ------------------------------------------------------------------
    logic [31:1] busy;
    logic [31:1] set_mask;
    logic [31:1] clr_mask;
    logic [31:0] busy_vec;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && issue_addr != 5'd0) begin
            set_mask[issue_addr] = 1'b1;
        end
        if (pop && fifo_addr[rd_ptr] != 5'd0) begin
            clr_mask[fifo_addr[rd_ptr]] = 1'b1;
        end
    end

    // OR-ing the set mask after the clear makes a same-edge set win.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    assign busy_vec = {busy, 1'b0};
    assign busy1    = busy_vec[query_addr1] && !rst;
    assign busy2    = busy_vec[query_addr2] && !rst;

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
`ifdef RF_ARB_STARVE_EN
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_next;
    logic       stall_q;

    always_comb begin
        starve_cnt_next = starve_cnt;
        if (fifo_empty || pop) begin
            starve_cnt_next = 4'd0;
        end else if (primary_active) begin
            starve_cnt_next = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
        end
    end

    // The compare is registered against the next count so stall_req tracks
    // the stored counter without a combinational path from wb_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
            stall_q    <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_next;
            stall_q    <= (starve_cnt_next >= 4'(STARVE_LIMIT));
        end
    end

    assign stall_req = stall_q && !rst;
`else
    assign stall_req = 1'b0;
`endif

endmodule
